// File: rtl/game_status_ctrl_multi.sv
// Game-flow controller for the snake family: START/PLAY/PAUSE/DIE/RESTART/OVER
// sequencing with a life count, timed die flashing and a timed restart pulse.
module game_status_ctrl_multi #(
  parameter int NUM_KEYS       = 4,
  parameter int NUM_LIVES      = 3,
  parameter int LIVES_W        = 4,
  parameter int FLASH_HALF     = 25_000_000,
  parameter int FLASH_TOGGLES  = 6,
  parameter int RESTART_CYCLES = 6,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_press,
  input  logic                pause_press,
  input  logic                hit_wall,
  input  logic                hit_body,
  output logic [2:0]          game_status,
  output logic                die_flash,
  output logic                restart,
  output logic [LIVES_W-1:0]  lives_left,
  output logic                game_over
);

  typedef enum logic [2:0] {
    S_RESTART = 3'd0,
    S_START   = 3'd1,
    S_PLAY    = 3'd2,
    S_DIE     = 3'd3,
    S_PAUSE   = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]   DIE_LAST   = CNT_W'((FLASH_TOGGLES + 1) * FLASH_HALF - 1);
  localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RESTART_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);

  // Raw 3-bit register so the unused codes 6/7 remain representable and recoverable.
  logic [2:0]         state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   counter, counter_nxt;
  logic [CNT_W-1:0]   half_cnt, half_cnt_nxt;
  logic               flash_nxt;
  logic               restart_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic               over_nxt;

  assign game_status = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_START;
      counter    <= '0;
      half_cnt   <= '0;
      die_flash  <= 1'b1;
      restart    <= 1'b0;
      lives_left <= LIVES_INIT;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      counter    <= counter_nxt;
      half_cnt   <= half_cnt_nxt;
      die_flash  <= flash_nxt;
      restart    <= restart_nxt;
      lives_left <= lives_nxt;
      game_over  <= over_nxt;
    end
  end

  always_comb begin
    state_nxt    = S_START;
    counter_nxt  = '0;
    half_cnt_nxt = '0;
    flash_nxt    = 1'b1;
    lives_nxt    = lives_left;

    case (state)
      S_START: state_nxt = (|key_press) ? S_PLAY : S_START;

      S_PLAY: begin
        if (hit_wall || hit_body) state_nxt = S_DIE;
        else if (pause_press)     state_nxt = S_PAUSE;
        else                      state_nxt = S_PLAY;
      end

      S_PAUSE: state_nxt = pause_press ? S_PLAY : S_PAUSE;

      S_DIE: begin
        if (counter == DIE_LAST) begin
          if (NUM_LIVES == 0) begin
            state_nxt = S_RESTART;
          end else if (lives_left == LIVES_W'(1)) begin
            lives_nxt = '0;
            state_nxt = S_OVER;
          end else begin
            lives_nxt = lives_left - LIVES_W'(1);
            state_nxt = S_RESTART;
          end
        end else begin
          // half_cnt tracks position within the current flash half-period
          state_nxt   = S_DIE;
          counter_nxt = counter + CNT_W'(1);
          if (half_cnt == HALF_LAST) begin
            flash_nxt = ~die_flash;
          end else begin
            half_cnt_nxt = half_cnt + CNT_W'(1);
            flash_nxt    = die_flash;
          end
        end
      end

      S_RESTART: begin
        if (counter == RST_LAST) begin
          state_nxt = S_START;
        end else begin
          state_nxt   = S_RESTART;
          counter_nxt = counter + CNT_W'(1);
        end
      end

      S_OVER: begin
        if (|key_press) begin
          state_nxt = S_RESTART;
          lives_nxt = LIVES_INIT;
        end else begin
          state_nxt = S_OVER;
        end
      end

      default: state_nxt = S_START;
    endcase

    restart_nxt = (state_nxt == S_RESTART);
    over_nxt    = (state_nxt == S_OVER);
  end

endmodule

// File: tb/tb_game_status_ctrl_multi.sv
// Directed bench for game_status_ctrl_multi: a NUM_LIVES=2 instance and an
// unlimited-lives (NUM_LIVES=0) instance, short flash/restart timing.
module tb_game_status_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_press;
  logic       pause_press, hit_wall, hit_body;
  logic [2:0] gs;
  logic       flash, rs, over;
  logic [3:0] lives;

  logic       z_rst;
  logic [3:0] z_key_press;
  logic       z_pause_press, z_hit_wall, z_hit_body;
  logic [2:0] z_gs;
  logic       z_flash, z_rs, z_over;
  logic [3:0] z_lives;

  int checks = 0;
  int errors = 0;

  logic [27:0] flash_pat;

  always #5 clk = ~clk;

  game_status_ctrl_multi #(
    .NUM_KEYS(4), .NUM_LIVES(2), .LIVES_W(4), .FLASH_HALF(4),
    .FLASH_TOGGLES(6), .RESTART_CYCLES(6), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .key_press(key_press), .pause_press(pause_press),
    .hit_wall(hit_wall), .hit_body(hit_body), .game_status(gs),
    .die_flash(flash), .restart(rs), .lives_left(lives), .game_over(over)
  );

  game_status_ctrl_multi #(
    .NUM_KEYS(4), .NUM_LIVES(0), .LIVES_W(4), .FLASH_HALF(4),
    .FLASH_TOGGLES(6), .RESTART_CYCLES(6), .CNT_W(32)
  ) dut_z (
    .clk(clk), .rst(z_rst), .key_press(z_key_press), .pause_press(z_pause_press),
    .hit_wall(z_hit_wall), .hit_body(z_hit_body), .game_status(z_gs),
    .die_flash(z_flash), .restart(z_rs), .lives_left(z_lives), .game_over(z_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_die();
    for (int i = 0; i < 28; i++) begin
      checks++;
      if (gs !== 3'd3) begin errors++; $display("FAIL die_status n=%0d: got %0d expected 3", i, gs); end
      checks++;
      if (flash !== flash_pat[27-i]) begin errors++; $display("FAIL die_flash n=%0d: got %0d expected %0d", i, flash, flash_pat[27-i]); end
      checks++;
      if (rs !== 1'b0 || over !== 1'b0) begin errors++; $display("FAIL die_quiet n=%0d: got restart=%0d game_over=%0d expected 0 0", i, rs, over); end
      tick();
    end
  endtask

  task automatic run_restart();
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (gs !== 3'd0 || rs !== 1'b1) begin errors++; $display("FAIL restart_pulse k=%0d: got status=%0d restart=%0d expected 0 1", j, gs, rs); end
      tick();
    end
    checks++;
    if (gs !== 3'd1 || rs !== 1'b0) begin errors++; $display("FAIL restart_end: got status=%0d restart=%0d expected 1 0", gs, rs); end
  endtask

  task automatic press_key(input logic [3:0] k);
    key_press = k;
    tick();
    key_press = '0;
  endtask

  task automatic hit(input logic wall);
    if (wall) hit_wall = 1'b1; else hit_body = 1'b1;
    tick();
    hit_wall = 1'b0;
    hit_body = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (gs !== 3'd1) begin errors++; $display("FAIL reset_status: got %0d expected 1", gs); end
    checks++;
    if (flash !== 1'b1) begin errors++; $display("FAIL reset_flash: got %0d expected 1", flash); end
    checks++;
    if (rs !== 1'b0) begin errors++; $display("FAIL reset_restart: got %0d expected 0", rs); end
    checks++;
    if (lives !== 4'd2) begin errors++; $display("FAIL reset_lives: got %0d expected 2", lives); end
    checks++;
    if (over !== 1'b0) begin errors++; $display("FAIL reset_over: got %0d expected 0", over); end
    pause_press = 1'b1;
    hit_wall = 1'b1;
    tick();
    pause_press = 1'b0;
    hit_wall = 1'b0;
    checks++;
    if (gs !== 3'd1) begin errors++; $display("FAIL start_ignores: got %0d expected 1", gs); end
  endtask

  task automatic test_start();
    press_key(4'b0100);
    checks++;
    if (gs !== 3'd2) begin errors++; $display("FAIL start_to_play: got %0d expected 2", gs); end
    checks++;
    if (lives !== 4'd2 || rs !== 1'b0 || flash !== 1'b1) begin
      errors++; $display("FAIL play_outputs: got lives=%0d restart=%0d flash=%0d expected 2 0 1", lives, rs, flash);
    end
  endtask

  task automatic test_die();
    hit(1'b0);
    run_die();
    checks++;
    if (lives !== 4'd1) begin errors++; $display("FAIL die_lives: got %0d expected 1", lives); end
    checks++;
    if (flash !== 1'b1) begin errors++; $display("FAIL restart_flash: got %0d expected 1", flash); end
    run_restart();
  endtask

  task automatic test_pause();
    press_key(4'b0010);
    pause_press = 1'b1;
    tick();
    pause_press = 1'b0;
    checks++;
    if (gs !== 3'd4) begin errors++; $display("FAIL pause_enter: got %0d expected 4", gs); end
    hit_wall = 1'b1;
    key_press = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (gs !== 3'd4) begin errors++; $display("FAIL pause_hold c=%0d: got %0d expected 4", i, gs); end
    end
    hit_wall = 1'b0;
    key_press = '0;
    pause_press = 1'b1;
    tick();
    pause_press = 1'b0;
    checks++;
    if (gs !== 3'd2) begin errors++; $display("FAIL pause_resume: got %0d expected 2", gs); end
    hit_wall = 1'b1;
    pause_press = 1'b1;
    tick();
    hit_wall = 1'b0;
    pause_press = 1'b0;
    checks++;
    if (gs !== 3'd3) begin errors++; $display("FAIL hit_beats_pause: got %0d expected 3", gs); end
  endtask

  task automatic test_reset_in_die();
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (flash !== flash_pat[27-i]) begin errors++; $display("FAIL abort_die_flash n=%0d: got %0d expected %0d", i, flash, flash_pat[27-i]); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (gs !== 3'd1 || flash !== 1'b1 || rs !== 1'b0 || lives !== 4'd2 || over !== 1'b0) begin
      errors++; $display("FAIL abort_die: got status=%0d flash=%0d restart=%0d lives=%0d over=%0d expected 1 1 0 2 0", gs, flash, rs, lives, over);
    end
    tick();
    checks++;
    if (gs !== 3'd1 || rs !== 1'b0) begin errors++; $display("FAIL abort_die_after: got status=%0d restart=%0d expected 1 0", gs, rs); end
  endtask

  task automatic test_reset_in_restart();
    press_key(4'b0001);
    hit(1'b1);
    run_die();
    tick(); tick(); tick();
    checks++;
    if (gs !== 3'd0 || rs !== 1'b1 || lives !== 4'd1) begin
      errors++; $display("FAIL restart_cycle3: got status=%0d restart=%0d lives=%0d expected 0 1 1", gs, rs, lives);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (gs !== 3'd1 || flash !== 1'b1 || rs !== 1'b0 || lives !== 4'd2) begin
      errors++; $display("FAIL abort_restart: got status=%0d flash=%0d restart=%0d lives=%0d expected 1 1 0 2", gs, flash, rs, lives);
    end
    tick();
    checks++;
    if (gs !== 3'd1 || rs !== 1'b0) begin errors++; $display("FAIL abort_restart_after: got status=%0d restart=%0d expected 1 0", gs, rs); end
  endtask

  task automatic test_over();
    press_key(4'b0100);
    hit(1'b0);
    run_die();
    checks++;
    if (lives !== 4'd1 || gs !== 3'd0) begin errors++; $display("FAIL over_first_death: got lives=%0d status=%0d expected 1 0", lives, gs); end
    run_restart();
    press_key(4'b1000);
    hit(1'b1);
    run_die();
    checks++;
    if (gs !== 3'd5 || over !== 1'b1 || lives !== 4'd0 || flash !== 1'b1 || rs !== 1'b0) begin
      errors++; $display("FAIL over_enter: got status=%0d over=%0d lives=%0d flash=%0d restart=%0d expected 5 1 0 1 0", gs, over, lives, flash, rs);
    end
    pause_press = 1'b1;
    hit_body = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gs !== 3'd5 || over !== 1'b1 || rs !== 1'b0) begin
        errors++; $display("FAIL over_hold c=%0d: got status=%0d over=%0d restart=%0d expected 5 1 0", i, gs, over, rs);
      end
    end
    pause_press = 1'b0;
    hit_body = 1'b0;
    press_key(4'b0001);
    checks++;
    if (gs !== 3'd0 || lives !== 4'd2 || over !== 1'b0) begin
      errors++; $display("FAIL over_exit: got status=%0d lives=%0d over=%0d expected 0 2 0", gs, lives, over);
    end
    run_restart();
  endtask

  task automatic test_bad_code();
    press_key(4'b0010);
    hit(1'b0);
    run_die();
    run_restart();
    force dut.state = 3'd7;
    tick();
    release dut.state;
    tick();
    checks++;
    if (gs !== 3'd1 || flash !== 1'b1 || rs !== 1'b0 || over !== 1'b0) begin
      errors++; $display("FAIL bad_code_recover: got status=%0d flash=%0d restart=%0d over=%0d expected 1 1 0 0", gs, flash, rs, over);
    end
    checks++;
    if (lives !== 4'd1) begin errors++; $display("FAIL bad_code_lives: got %0d expected 1", lives); end
  endtask

  task automatic test_unlimited();
    z_rst = 1'b1;
    tick();
    z_rst = 1'b0;
    checks++;
    if (z_gs !== 3'd1 || z_lives !== 4'd0 || z_flash !== 1'b1) begin
      errors++; $display("FAIL z_reset: got status=%0d lives=%0d flash=%0d expected 1 0 1", z_gs, z_lives, z_flash);
    end
    for (int d = 0; d < 5; d++) begin
      z_key_press = 4'b0100;
      tick();
      z_key_press = '0;
      z_hit_wall = 1'b1;
      tick();
      z_hit_wall = 1'b0;
      for (int i = 0; i < 28; i++) begin
        checks++;
        if (z_gs !== 3'd3) begin errors++; $display("FAIL z_die d=%0d n=%0d: got %0d expected 3", d, i, z_gs); end
        tick();
      end
      checks++;
      if (z_gs !== 3'd0 || z_lives !== 4'd0 || z_over !== 1'b0 || z_rs !== 1'b1) begin
        errors++; $display("FAIL z_after_die d=%0d: got status=%0d lives=%0d over=%0d restart=%0d expected 0 0 0 1", d, z_gs, z_lives, z_over, z_rs);
      end
      for (int j = 0; j < 6; j++) tick();
      checks++;
      if (z_gs !== 3'd1 || z_rs !== 1'b0) begin
        errors++; $display("FAIL z_back_to_start d=%0d: got status=%0d restart=%0d expected 1 0", d, z_gs, z_rs);
      end
    end
  endtask

  initial begin
    flash_pat     = 28'b1111_0000_1111_0000_1111_0000_1111;
    rst           = 1'b0;
    key_press     = '0;
    pause_press   = 1'b0;
    hit_wall      = 1'b0;
    hit_body      = 1'b0;
    z_rst         = 1'b1;
    z_key_press   = '0;
    z_pause_press = 1'b0;
    z_hit_wall    = 1'b0;
    z_hit_body    = 1'b0;
    #2;
    test_reset();
    test_start();
    test_die();
    test_pause();
    test_reset_in_die();
    test_reset_in_restart();
    test_over();
    test_bad_code();
    test_unlimited();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
